// File: rtl/conv_mem_host.sv
// rtl/conv_mem_host.sv - image/coefficient memory host around a convolution engine
//
// Loads a full image over a valid/ready stream, offers it to the engine (ready/busy
// handshake), exposes L0/L1 result memories on a control port, then drains L1 (and
// optionally L0 first) over a valid/ready output stream.
//
// Optional feature macro: CONV_L0_DUMP_EN (drain streams L0 before L1).
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid, in_data, in_ready    image pixel input stream
//   ready, busy                    image offered to engine / engine running
//   iaddr, idata                   engine image read port (combinational)
//   cwr, caddr_wr, cdata_wr        L0/L1 write port, target chosen by csel
//   crd, caddr_rd, cdata_rd        L0/L1 read port (combinational), target chosen by csel
//   csel                           3'b001 = L0, 3'b011 = L1, others ignored
//   out_valid, out_data, out_ready output stream of result memory contents
//   out_last, done                 final output word / drain finished
module conv_mem_host #(
    parameter int IMG_WORDS = 4096,
    parameter int L1_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [19:0] in_data,
    output logic        in_ready,
    output logic        ready,
    input  logic        busy,
    input  logic [11:0] iaddr,
    output logic [19:0] idata,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [19:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    output logic [19:0] cdata_rd,
    input  logic [2:0]  csel,
    output logic        out_valid,
    output logic [19:0] out_data,
    input  logic        out_ready,
    output logic        out_last,
    output logic        done
);

    localparam int              IAW      = $clog2(IMG_WORDS);
    localparam int              LAW      = $clog2(L1_WORDS);
    localparam logic [IAW-1:0]  IMG_LAST = IAW'(IMG_WORDS - 1);
    localparam logic [LAW-1:0]  L1_LAST  = LAW'(L1_WORDS - 1);
    localparam logic [12:0]     L1_LIM   = 13'(L1_WORDS);

    typedef enum logic [2:0] {S_LOAD, S_OFFER, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IAW-1:0] wcnt;
    logic [IAW-1:0] wr_ptr;
    logic [LAW-1:0] rcnt;
    logic           in_fire;
    logic           out_fire;
    logic           l1_phase;
    logic           l0_sel;
    logic           l1_sel;
    logic           l1_wr_ok;
    logic           l1_rd_ok;

    logic [19:0] img_mem [IMG_WORDS];
    logic [19:0] l0_mem  [IMG_WORDS];
    logic [19:0] l1_mem  [L1_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ready     = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wcnt == IMG_LAST) begin
                    state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                ready = 1'b1;
                if (busy) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Entry to RUN already required busy=1, so busy=0 here is its falling edge.
                if (!busy) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && out_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // A word accepted in DONE starts a fresh image at address 0.
    assign wr_ptr   = (state == S_DONE) ? '0 : wcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= '0;
        end else if (in_fire) begin
            if (state == S_DONE) begin
                wcnt <= IAW'(1);
            end else if (wcnt == IMG_LAST) begin
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    // Image storage is never cleared; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (in_fire && !reset) begin
            img_mem[wr_ptr] <= in_data;
        end
    end

    assign idata = img_mem[iaddr[IAW-1:0]];

    assign l0_sel   = (csel == 3'b001);
    assign l1_sel   = (csel == 3'b011);
    assign l1_wr_ok = ({1'b0, caddr_wr} < L1_LIM);
    assign l1_rd_ok = ({1'b0, caddr_rd} < L1_LIM);

    always_ff @(posedge clk) begin
        if (cwr && l0_sel) begin
            l0_mem[caddr_wr[IAW-1:0]] <= cdata_wr;
        end
        if (cwr && l1_sel && l1_wr_ok) begin
            l1_mem[caddr_wr[LAW-1:0]] <= cdata_wr;
        end
    end

    // Asynchronous read of the pre-edge contents gives old data on a same-address write.
    always_comb begin
        cdata_rd = '0;
        if (crd && l0_sel) begin
            cdata_rd = l0_mem[caddr_rd[IAW-1:0]];
        end else if (crd && l1_sel && l1_rd_ok) begin
            cdata_rd = l1_mem[caddr_rd[LAW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt <= '0;
        end else if (state == S_RUN) begin
            rcnt <= '0;
        end else if (out_fire && l1_phase) begin
            rcnt <= rcnt + 1'b1;
        end
    end

`ifdef CONV_L0_DUMP_EN
    logic           l0_phase;
    logic [IAW-1:0] dcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l0_phase <= 1'b0;
            dcnt     <= '0;
        end else if (state == S_RUN) begin
            l0_phase <= 1'b1;
            dcnt     <= '0;
        end else if (out_fire && l0_phase) begin
            dcnt <= dcnt + 1'b1;
            if (dcnt == IMG_LAST) begin
                l0_phase <= 1'b0;
            end
        end
    end

    assign l1_phase = !l0_phase;
    assign out_data = l0_phase ? l0_mem[dcnt] : l1_mem[rcnt];
`else
    assign l1_phase = 1'b1;
    assign out_data = l1_mem[rcnt];
`endif

    assign out_last = (state == S_DRAIN) && l1_phase && (rcnt == L1_LAST);

endmodule

// File: tb/tb_conv_mem_host.sv
// tb/tb_conv_mem_host.sv - self-checking bench for conv_mem_host
module tb_conv_mem_host;

    localparam int NIMG = 4096;
    localparam int NL1  = 1024;
`ifdef CONV_L0_DUMP_EN
    localparam int NOUT = NIMG + NL1;
`else
    localparam int NOUT = NL1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [19:0] in_data;
    logic        in_ready;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ready;
    logic        out_last;
    logic        done;

    always #5 clk = ~clk;

    conv_mem_host dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    logic [19:0] img_m [NIMG];
    logic [19:0] l0_m  [NIMG];
    logic [19:0] l1_m  [NL1];
    logic [19:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          fill_sel = 0;
    int          fill_n   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input bit idx_data);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 4 * n) begin
            tick();
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = idx_data ? 20'(acc) : 20'($urandom);
            if (fill_sel != 0 && cyc < fill_n) begin
                cwr      = 1'b1;
                csel     = 3'(fill_sel);
                caddr_wr = 12'(cyc);
                cdata_wr = 20'($urandom);
                if (fill_sel == 1) l0_m[cyc] = cdata_wr;
                else               l1_m[cyc] = cdata_wr;
            end else begin
                cwr = 1'b0;
            end
            #1;
            if (in_valid) begin
                check("load_in_ready", in_ready, 1);
                img_m[acc] = in_data;
                acc++;
            end
            cyc++;
        end
        tick();
        in_valid = 1'b0;
        cwr      = 1'b0;
        check("load_count", acc, n);
    endtask

    task automatic sample_img(input string tag);
        for (int i = 0; i < 8; i++) begin
            iaddr = 12'($urandom_range(0, NIMG - 1));
            #1;
            check(tag, idata, img_m[iaddr]);
        end
    endtask

    initial begin
        int k;
        int cyc;
        bit orr;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; busy = 1'b0; iaddr = '0;
        cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
        csel = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_ready", ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);

        // Image = index, L0 filled with random words concurrently (writes during LOAD).
        fill_sel = 1; fill_n = NIMG;
        load(NIMG, 1'b1);
        fill_sel = 0;
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_ready", ready, 1);
        iaddr = 12'h0A5;
        #1;
        check("idata_0a5", idata, 20'h000A5);
        sample_img("idata_load1");

        // OFFER: busy low for 10 cycles, stray input words must be ignored.
        in_valid = 1'b1; in_data = 20'hFFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("offer_ready", ready, 1);
            check("offer_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        busy = 1'b1;
        #1;
        check("offer_ready_busy", ready, 1);
        tick();
        check("run_ready", ready, 0);
        iaddr = 12'd0;
        #1;
        check("img0_untouched", idata, img_m[0]);
        check("run_out_valid", out_valid, 0);

        // RUN: fill L1, exercise control port rules.
        for (int i = 0; i < NL1; i++) begin
            tick();
            cwr = 1'b1; csel = 3'b011; caddr_wr = 12'(i); cdata_wr = 20'($urandom);
            l1_m[i] = cdata_wr;
        end
        tick();
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd5; cdata_wr = 20'h12345;
        l0_m[5] = 20'h12345;
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
        #1;
        check("l0_rd5", cdata_rd, 20'h12345);
        cwr = 1'b1; caddr_wr = 12'd5; cdata_wr = 20'h0ABCD;
        #1;
        check("rw_same_old", cdata_rd, 20'h12345);
        tick();
        cwr = 1'b0; l0_m[5] = 20'h0ABCD;
        #1;
        check("rw_same_new", cdata_rd, 20'h0ABCD);
        cwr = 1'b1; csel = 3'b010; cdata_wr = 20'h55555;
        tick();
        cwr = 1'b0; csel = 3'b001;
        #1;
        check("bad_csel_wr", cdata_rd, l0_m[5]);
        csel = 3'b010;
        #1;
        check("bad_csel_rd", cdata_rd, 0);
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd1024; cdata_wr = 20'h77777;
        tick();
        cwr = 1'b0; caddr_rd = 12'd0;
        #1;
        check("l1_oob_wr", cdata_rd, l1_m[0]);
        caddr_rd = 12'd1024;
        #1;
        check("l1_oob_rd", cdata_rd, 0);
        crd = 1'b0; caddr_rd = 12'd0;
        #1;
        check("crd_low", cdata_rd, 0);
        crd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                csel = 3'b001; caddr_rd = 12'($urandom_range(0, NIMG - 1));
                #1;
                check("l0_rand_rd", cdata_rd, l0_m[caddr_rd]);
            end else begin
                csel = 3'b011; caddr_rd = 12'($urandom_range(0, NL1 - 1));
                #1;
                check("l1_rand_rd", cdata_rd, l1_m[caddr_rd]);
            end
        end
        crd = 1'b0;

        // DRAIN with out_ready toggling every cycle.
`ifdef CONV_L0_DUMP_EN
        foreach (l0_m[i]) exp_q.push_back(l0_m[i]);
`endif
        foreach (l1_m[i]) exp_q.push_back(l1_m[i]);
        busy = 1'b0;
        tick();
        k = 0; cyc = 0; orr = 1'b1;
        while (k < NOUT && cyc < 3 * NOUT) begin
            out_ready = orr;
            #1;
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, exp_q[k]);
            check("drain_last", out_last, (k == NOUT - 1) ? 1 : 0);
            check("drain_done_low", done, 0);
            if (orr) k++;
            orr = !orr;
            cyc++;
            tick();
        end
        out_ready = 1'b0;
        #1;
        check("drain_count", k, NOUT);
        check("done_high", done, 1);
        check("done_out_valid", out_valid, 0);
        check("done_in_ready", in_ready, 1);

        // Restart from DONE, abort with reset at wcnt=2000.
        load(2000, 1'b0);
        check("reload_done_low", done, 0);
        check("reload_in_ready", in_ready, 1);
        iaddr = 12'd0;
        #1;
        check("restart_at_0", idata, img_m[0]);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_done", done, 0);
        iaddr = 12'd1999;
        #1;
        check("keep_1999", idata, img_m[1999]);
        iaddr = 12'd2000;
        #1;
        check("keep_2000", idata, 20'd2000);
        iaddr = 12'd4095;
        #1;
        check("keep_4095", idata, 20'd4095);
        tick();
        tick();
        reset = 1'b0;
        load(NIMG, 1'b0);
        #1;
        check("reload_ready", ready, 1);
        check("reload_full_in_ready", in_ready, 0);
        iaddr = 12'd0;
        #1;
        check("reload_img0", idata, img_m[0]);
        sample_img("idata_load2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
